// File: rtl/mpu_pkg.sv
// Shared constants, state encoding and flat-bus layout for the matrix loader
// and the determinant stage that consumes its output.
package mpu_pkg;

  localparam int MAX_N     = 5;
  localparam int ELEM_W    = 8;
  localparam int MPU_BUS_W = MAX_N * MAX_N * ELEM_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Lowest bit of element (r,c) inside the row-major flat matrix bus.
  function automatic int flat_lo(input int r, input int c);
    return (r * MAX_N + c) * ELEM_W;
  endfunction

endpackage

// File: rtl/mpu_matrix_loader_if.sv
// Command, element-stream and result handshake signals of the matrix loader.
interface mpu_matrix_loader_if;
    import mpu_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [7:0]           cmd_size;
    logic                 in_valid;
    logic                 in_ready;
    logic [ELEM_W-1:0]    in_data;
    logic                 abort;
    logic                 mat_valid;
    logic                 mat_ack;
    logic [MPU_BUS_W-1:0] matrix_flat;
    logic [7:0]           size_out;
    logic                 err;

    modport master (
        output cmd_valid, cmd_size, in_valid, in_data, abort, mat_ack,
        input  cmd_ready, in_ready, mat_valid, matrix_flat, size_out, err
    );

    modport slave (
        input  cmd_valid, cmd_size, in_valid, in_data, abort, mat_ack,
        output cmd_ready, in_ready, mat_valid, matrix_flat, size_out, err
    );

endinterface

// File: rtl/mpu_rc_counter.sv
// Row/column write pointer for a size x size row-major fill.
module mpu_rc_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       step,
    input  logic [2:0] size,
    output logic [2:0] row,
    output logic [2:0] col,
    output logic       last,
    output logic       row_wrap
);

    assign row_wrap = (col == size - 3'd1);
    assign last     = row_wrap && (row == size - 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= 3'd0;
            col <= 3'd0;
        end else if (clear) begin
            row <= 3'd0;
            col <= 3'd0;
        end else if (step) begin
            if (row_wrap) begin
                col <= 3'd0;
                row <= row + 3'd1;
            end else begin
                col <= col + 3'd1;
            end
        end
    end

endmodule

// File: rtl/mpu_matrix_loader.sv
// Loads a size command plus a row-major byte stream into a zero-filled 5x5
// array and holds it for the determinant stage until acknowledged.
module mpu_matrix_loader
    import mpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    mpu_matrix_loader_if.slave bus
);

    state_t               state;
    state_t               state_nx;
    logic [MPU_BUS_W-1:0] mat_q;
    logic [7:0]           size_q;
    logic                 err_q;
    logic                 err_nx;
    logic                 cmd_legal;
    logic                 take_cmd;
    logic                 cnt_clear;
    logic                 step;
    logic                 load_done;
    logic [2:0]           row;
    logic [2:0]           col;
    logic                 last;
    logic                 row_wrap;

    assign cmd_legal = (bus.cmd_size != 8'd0) && (bus.cmd_size <= 8'(MAX_N));
    assign load_done = step && row_wrap && last;

    mpu_rc_counter u_rc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .step     (step),
        .size     (size_q[2:0]),
        .row      (row),
        .col      (col),
        .last     (last),
        .row_wrap (row_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Abort overrides every other event, including a concurrent accept.
    always_comb begin
        state_nx  = state;
        take_cmd  = 1'b0;
        cnt_clear = 1'b0;
        step      = 1'b0;
        err_nx    = 1'b0;
        if (bus.abort) begin
            state_nx  = IDLE;
            cnt_clear = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        if (cmd_legal) begin
                            take_cmd  = 1'b1;
                            cnt_clear = 1'b1;
                            state_nx  = LOAD;
                        end else begin
                            err_nx = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    step = bus.in_valid;
                end
                HOLD: begin
                    if (bus.mat_ack) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
            if (load_done) state_nx = HOLD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat_q  <= '0;
            size_q <= 8'd0;
            err_q  <= 1'b0;
        end else begin
            err_q <= err_nx;
            if (take_cmd) size_q <= bus.cmd_size;
            if (cnt_clear) begin
                mat_q <= '0;
            end else if (step) begin
                mat_q[flat_lo(int'(row), int'(col)) +: ELEM_W] <= bus.in_data;
            end
        end
    end

    assign bus.cmd_ready   = (state == IDLE);
    assign bus.in_ready    = (state == LOAD);
    assign bus.mat_valid   = (state == HOLD);
    assign bus.matrix_flat = mat_q;
    assign bus.size_out    = size_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Directed bench for mpu_matrix_loader: loads, illegal sizes, stalls, hold, abort, async reset.
module tb_mpu_matrix_loader;
    import mpu_pkg::*;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;
    logic [7:0] exp_m [MAX_N][MAX_N];

    mpu_matrix_loader_if bus ();

    mpu_matrix_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] elem(input int r, input int c);
        return bus.matrix_flat[flat_lo(r, c) +: ELEM_W];
    endfunction

    task automatic clear_exp();
        for (int r = 0; r < MAX_N; r++)
            for (int c = 0; c < MAX_N; c++)
                exp_m[r][c] = 8'h00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total_cnt++;
        if (bus.cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready);
        else pass_cnt++;
        total_cnt++;
        if (bus.in_ready !== 1'b0 || bus.mat_valid !== 1'b0 || bus.err !== 1'b0)
            $display("FAIL reset_flags in_ready=%b mat_valid=%b err=%b exp=0", bus.in_ready, bus.mat_valid, bus.err);
        else pass_cnt++;
        total_cnt++;
        if (bus.matrix_flat !== '0 || bus.size_out !== 8'd0)
            $display("FAIL reset_data matrix=%h size=%0d exp=0", bus.matrix_flat, bus.size_out);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_size3();
        bus.cmd_valid = 1'b1;
        bus.cmd_size  = 8'd3;
        tick();
        bus.cmd_valid = 1'b0;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL s3_in_ready got=%b exp=1", bus.in_ready);
        else pass_cnt++;
        clear_exp();
        bus.in_valid = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            bus.in_data = 8'(k);
            exp_m[(k-1)/3][(k-1)%3] = 8'(k);
            if (k == 9) begin
                total_cnt++;
                if (bus.mat_valid !== 1'b0) $display("FAIL s3_early_valid got=%b exp=0", bus.mat_valid);
                else pass_cnt++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.mat_valid !== 1'b1) $display("FAIL s3_mat_valid got=%b exp=1", bus.mat_valid);
        else pass_cnt++;
        total_cnt++;
        if (elem(0,0) !== 8'd1 || elem(1,2) !== 8'd6 || elem(2,2) !== 8'd9)
            $display("FAIL s3_corners got=%0d,%0d,%0d exp=1,6,9", elem(0,0), elem(1,2), elem(2,2));
        else pass_cnt++;
        for (int r = 0; r < MAX_N; r++)
            for (int c = 0; c < MAX_N; c++) begin
                total_cnt++;
                if (elem(r,c) !== exp_m[r][c]) $display("FAIL s3_elem r=%0d c=%0d got=%h exp=%h", r, c, elem(r,c), exp_m[r][c]);
                else pass_cnt++;
            end
        total_cnt++;
        if (bus.size_out !== 8'd3) $display("FAIL s3_size got=%0d exp=3", bus.size_out);
        else pass_cnt++;
        bus.mat_ack = 1'b1;
        tick();
        bus.mat_ack = 1'b0;
        total_cnt++;
        if (bus.mat_valid !== 1'b0 || bus.cmd_ready !== 1'b1)
            $display("FAIL s3_ack mat_valid=%b cmd_ready=%b exp=0,1", bus.mat_valid, bus.cmd_ready);
        else pass_cnt++;
    endtask

    task automatic test_bad_size();
        logic [7:0] bad [2];
        bad[0] = 8'd0;
        bad[1] = 8'd6;
        for (int i = 0; i < 2; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_size  = bad[i];
            tick();
            bus.cmd_valid = 1'b0;
            total_cnt++;
            if (bus.err !== 1'b1) $display("FAIL bad_err_pulse size=%0d got=%b exp=1", bad[i], bus.err);
            else pass_cnt++;
            total_cnt++;
            if (bus.cmd_ready !== 1'b1 || bus.in_ready !== 1'b0 || bus.size_out !== 8'd3)
                $display("FAIL bad_state size=%0d cmd_ready=%b in_ready=%b size_out=%0d exp=1,0,3", bad[i], bus.cmd_ready, bus.in_ready, bus.size_out);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (bus.err !== 1'b0) $display("FAIL bad_err_width size=%0d got=%b exp=0", bad[i], bus.err);
            else pass_cnt++;
        end
    endtask

    task automatic test_gaps();
        int k;
        int cycles;
        int rises;
        logic prev_valid;
        logic accept;
        k = 0; cycles = 0; rises = 0; prev_valid = 1'b0;
        clear_exp();
        bus.cmd_valid = 1'b1;
        bus.cmd_size  = 8'd5;
        tick();
        bus.cmd_valid = 1'b0;
        while (k < 25 && cycles < 200) begin
            bus.in_valid = ((cycles % 3) != 2) && ((cycles % 7) != 4);
            bus.in_data  = 8'(k + 16);
            accept = bus.in_valid && bus.in_ready;
            tick();
            if (accept) begin
                exp_m[k/5][k%5] = 8'(k + 16);
                k++;
            end
            if (bus.mat_valid && !prev_valid) rises++;
            prev_valid = bus.mat_valid;
            cycles++;
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.mat_valid && !prev_valid) rises++;
            prev_valid = bus.mat_valid;
        end
        total_cnt++;
        if (k !== 25) $display("FAIL gaps_count got=%0d exp=25", k);
        else pass_cnt++;
        total_cnt++;
        if (rises !== 1) $display("FAIL gaps_rises got=%0d exp=1", rises);
        else pass_cnt++;
        for (int r = 0; r < MAX_N; r++)
            for (int c = 0; c < MAX_N; c++) begin
                total_cnt++;
                if (elem(r,c) !== exp_m[r][c]) $display("FAIL gaps_elem r=%0d c=%0d got=%h exp=%h", r, c, elem(r,c), exp_m[r][c]);
                else pass_cnt++;
            end
    endtask

    task automatic test_hold_cmd();
        bus.cmd_valid = 1'b1;
        bus.cmd_size  = 8'd2;
        for (int i = 0; i < 3; i++) tick();
        total_cnt++;
        if (bus.cmd_ready !== 1'b0 || bus.mat_valid !== 1'b1 || bus.size_out !== 8'd5)
            $display("FAIL hold_block cmd_ready=%b mat_valid=%b size=%0d exp=0,1,5", bus.cmd_ready, bus.mat_valid, bus.size_out);
        else pass_cnt++;
        total_cnt++;
        if (elem(4,4) !== 8'd40 || elem(0,0) !== 8'd16)
            $display("FAIL hold_frozen got=%h,%h exp=28,10", elem(4,4), elem(0,0));
        else pass_cnt++;
        bus.mat_ack = 1'b1;
        tick();
        bus.mat_ack = 1'b0;
        total_cnt++;
        if (bus.mat_valid !== 1'b0 || bus.cmd_ready !== 1'b1)
            $display("FAIL hold_ack mat_valid=%b cmd_ready=%b exp=0,1", bus.mat_valid, bus.cmd_ready);
        else pass_cnt++;
        total_cnt++;
        if (bus.size_out !== 8'd5 || elem(4,4) !== 8'd40)
            $display("FAIL hold_persist size=%0d e44=%h exp=5,28", bus.size_out, elem(4,4));
        else pass_cnt++;
        tick();
        bus.cmd_valid = 1'b0;
        total_cnt++;
        if (bus.in_ready !== 1'b1 || bus.size_out !== 8'd2 || bus.matrix_flat !== '0)
            $display("FAIL hold_pending in_ready=%b size=%0d matrix=%h exp=1,2,0", bus.in_ready, bus.size_out, bus.matrix_flat);
        else pass_cnt++;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        total_cnt++;
        if (bus.cmd_ready !== 1'b1 || bus.err !== 1'b0)
            $display("FAIL hold_abort cmd_ready=%b err=%b exp=1,0", bus.cmd_ready, bus.err);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        bus.cmd_valid = 1'b1;
        bus.cmd_size  = 8'd4;
        tick();
        bus.cmd_valid = 1'b0;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 7; k++) begin
            bus.in_data = 8'(k + 1);
            tick();
        end
        total_cnt++;
        if (elem(1,2) !== 8'd7) $display("FAIL abort_pre got=%h exp=07", elem(1,2));
        else pass_cnt++;
        bus.in_data = 8'd8;
        bus.abort   = 1'b1;
        tick();
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.cmd_ready !== 1'b1 || bus.in_ready !== 1'b0 || bus.err !== 1'b0)
            $display("FAIL abort_state cmd_ready=%b in_ready=%b err=%b exp=1,0,0", bus.cmd_ready, bus.in_ready, bus.err);
        else pass_cnt++;
        total_cnt++;
        if (bus.matrix_flat !== '0) $display("FAIL abort_clear got=%h exp=0", bus.matrix_flat);
        else pass_cnt++;
        clear_exp();
        bus.cmd_valid = 1'b1;
        bus.cmd_size  = 8'd2;
        tick();
        bus.cmd_valid = 1'b0;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.in_data = 8'(8'hA1 + k);
            exp_m[k/2][k%2] = 8'(8'hA1 + k);
            tick();
        end
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.mat_valid !== 1'b1 || bus.size_out !== 8'd2)
            $display("FAIL abort_reload mat_valid=%b size=%0d exp=1,2", bus.mat_valid, bus.size_out);
        else pass_cnt++;
        for (int r = 0; r < MAX_N; r++)
            for (int c = 0; c < MAX_N; c++) begin
                total_cnt++;
                if (elem(r,c) !== exp_m[r][c]) $display("FAIL abort_elem r=%0d c=%0d got=%h exp=%h", r, c, elem(r,c), exp_m[r][c]);
                else pass_cnt++;
            end
        bus.mat_ack = 1'b1;
        tick();
        bus.mat_ack = 1'b0;
    endtask

    task automatic test_async_reset();
        bus.cmd_valid = 1'b1;
        bus.cmd_size  = 8'd5;
        tick();
        bus.cmd_valid = 1'b0;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            bus.in_data = 8'(k + 1);
            tick();
        end
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.in_ready !== 1'b1 || elem(2,1) !== 8'd12)
            $display("FAIL areset_pre in_ready=%b e21=%h exp=1,0c", bus.in_ready, elem(2,1));
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bus.matrix_flat !== '0 || bus.size_out !== 8'd0)
            $display("FAIL areset_data matrix=%h size=%0d exp=0", bus.matrix_flat, bus.size_out);
        else pass_cnt++;
        total_cnt++;
        if (bus.cmd_ready !== 1'b1 || bus.in_ready !== 1'b0 || bus.mat_valid !== 1'b0)
            $display("FAIL areset_ctrl cmd_ready=%b in_ready=%b mat_valid=%b exp=1,0,0", bus.cmd_ready, bus.in_ready, bus.mat_valid);
        else pass_cnt++;
        #3;
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if (bus.cmd_ready !== 1'b1) $display("FAIL areset_release got=%b exp=1", bus.cmd_ready);
        else pass_cnt++;
        clear_exp();
        exp_m[0][0] = 8'hFF;
        bus.cmd_valid = 1'b1;
        bus.cmd_size  = 8'd1;
        tick();
        bus.cmd_valid = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hFF;
        tick();
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.mat_valid !== 1'b1 || bus.size_out !== 8'd1)
            $display("FAIL size1_valid mat_valid=%b size=%0d exp=1,1", bus.mat_valid, bus.size_out);
        else pass_cnt++;
        for (int r = 0; r < MAX_N; r++)
            for (int c = 0; c < MAX_N; c++) begin
                total_cnt++;
                if (elem(r,c) !== exp_m[r][c]) $display("FAIL size1_elem r=%0d c=%0d got=%h exp=%h", r, c, elem(r,c), exp_m[r][c]);
                else pass_cnt++;
            end
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        bus.cmd_valid = 1'b0;
        bus.cmd_size  = 8'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'd0;
        bus.abort     = 1'b0;
        bus.mat_ack   = 1'b0;
        test_reset();
        test_size3();
        test_bad_size();
        test_gaps();
        test_hold_cmd();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mpu_matrix_loader.md
Name: mpu_matrix_loader

Overview:
- Upstream stage of the determinant unit. Accepts a size command, then matrix elements as a row-major byte stream over a valid/ready handshake.
- Stores the elements into a 5x5 register array and zero-fills every unused element.
- Presents the flat matrix and the size to the determinant stage with a valid/ack handshake.
- Holds the matrix stable until the consumer acknowledges, so the combinational determinant result is valid for the whole hold window.

Parameters:
- MAX_N, 5, maximum matrix dimension; array is MAX_N x MAX_N.
- ELEM_W, 8, element width in bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  size command present.
- cmd_ready  out  1  loader can accept a command (IDLE only).
- cmd_size  in  8  requested dimension; legal values are 1..MAX_N.
- in_valid  in  1  element byte present.
- in_ready  out  1  loader accepts elements (LOAD only).
- in_data  in  ELEM_W  element value, row-major order.
- abort  in  1  synchronous cancel; highest priority after reset.
- mat_valid  out  1  matrix and size_out are stable and complete.
- mat_ack  in  1  consumer has taken the result.
- matrix_flat  out  MAX_N*MAX_N*ELEM_W  element (r,c) is at bits [(r*MAX_N+c)*ELEM_W +: ELEM_W].
- size_out  out  8  captured dimension.
- err  out  1  one-cycle pulse on an illegal size command.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - matrix_flat, size_out, row, col, mat_valid, in_ready and err all reset to 0.
  - cmd_ready resets to 1.
- Outputs decode from registered state:
  - cmd_ready = (state == IDLE).
  - in_ready = (state == LOAD).
  - mat_valid = (state == HOLD).
- IDLE:
  - A cmd_valid with cmd_size in 1..MAX_N is accepted. On that edge: size_out is captured, the whole array is cleared to 0, row and col are set to 0, and the state goes to LOAD.
  - A cmd_valid with cmd_size of 0 or greater than MAX_N pulses err for exactly one cycle. State stays IDLE and size_out is unchanged.
- LOAD:
  - Each cycle with in_valid && in_ready writes in_data to (row,col).
  - col increments; when col == size_out-1 it wraps to 0 and row increments.
  - When the accepted byte is at (size_out-1, size_out-1), the state goes to HOLD on that same edge. mat_valid is high the next cycle, giving 1 cycle of latency from the last accepted byte.
  - in_valid low stalls without changing any state. There is no timeout.
- HOLD:
  - matrix_flat and size_out are frozen. in_ready and cmd_ready are 0, so a cmd_valid presented here is not consumed.
  - mat_ack for one cycle moves the state to IDLE; mat_valid drops the next cycle.
  - The earliest the next command can be accepted is the cycle after the ack.
- Array contents persist after ack until the next accepted command clears them.
- abort (any state):
  - Next state is IDLE, the array is cleared, and row and col are set to 0.
  - Abort wins over a simultaneous element accept, ack or command. err is not asserted.
- size 1: a single byte completes the load, and the state goes LOAD to HOLD after one accept.
- Elements outside size_out x size_out are always 0 whenever mat_valid is 1.
- Width rules:
  - Elements are stored unmodified.
  - row and col are 3 bits each, compared against size_out[2:0] after legality is checked.
- Reset mid-LOAD or mid-HOLD discards all data immediately; outputs take their reset values asynchronously.

Decomposition:
- Package mpu_pkg holds:
  - MAX_N, ELEM_W and the MPU_BUS_W = MAX_N*MAX_N*ELEM_W constant.
  - The state enum {IDLE, LOAD, HOLD}.
  - An index function flat_lo(r,c) returning (r*MAX_N+c)*ELEM_W.
  - The determinant stage imports the same package so the flat bus layout is defined in one place.
- One sub-module, mpu_rc_counter: a row/col counter with clear, step and size inputs, and last-element and row-wrap outputs.
- The FSM and the storage array stay in the top level.

Test Plan:
- Reset, then cmd_size=3, stream bytes 1..9 with in_valid held high:
  - mat_valid is high one cycle after the 9th byte.
  - (0,0)=1, (1,2)=6 and (2,2)=9.
  - All elements with r≥3 or c≥3 are 0.
  - size_out=3.
- cmd_size=0, then cmd_size=6:
  - Each produces a one-cycle err pulse.
  - State stays IDLE, cmd_ready stays 1, and size_out keeps its prior value.
- cmd_size=5, 25 bytes with random in_valid gaps:
  - No byte is lost or duplicated; byte k lands at (k/5, k%5).
  - mat_valid rises exactly once.
- In HOLD, drive cmd_valid (size 2) without ack:
  - cmd_ready=0, the matrix is unchanged and the command is not consumed.
  - Drive mat_ack: mat_valid is 0 the next cycle and the pending command is accepted the cycle after.
- cmd_size=4, abort after 7 bytes in the same cycle as an accepted byte:
  - State is IDLE, the array is all 0 and no err.
  - A new size-2 load with 4 bytes then completes correctly.
- Assert rst_n low asynchronously mid-LOAD (size 5, 12 bytes in):
  - Outputs clear immediately, without waiting for a clock edge.
  - After release, cmd_ready=1 and a size-1 load of 0xFF gives (0,0)=0xFF with all other elements 0.
